// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a one-entry holding register, clocked at the oversample rate
module uart_tx #(
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_16x,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int TW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift_reg, shift_n, hold_reg, hold_n;
  logic hold_full, full_n, txd_n, accept, last_tick, stop_last;
  assign accept = tx_valid && tx_ready;
  assign last_tick = tick == TW'(OVERSAMPLE - 1);
  assign stop_last = state == STOP && last_tick;
  assign tx_ready = !hold_full;
  assign tx_busy = state != IDLE;
  assign tx_done = stop_last;
  // next state, counters and buffers; txd is precomputed from the next state so the line is registered
  always_comb begin
    state_n = state;
    tick_n = (state == IDLE || last_tick) ? '0 : tick + TW'(1);
    bit_n = bit_idx;
    shift_n = shift_reg;
    hold_n = hold_reg;
    full_n = hold_full;
    if (accept && tx_busy && !stop_last) begin
      hold_n = tx_data;
      full_n = 1'b1;
    end
    case (state)
      IDLE: if (accept) begin
        shift_n = tx_data;
        state_n = START;
      end
      START: if (last_tick) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (last_tick) begin
        bit_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (last_tick) state_n = STOP;
      STOP: if (last_tick) begin
        if (hold_full) begin
          shift_n = hold_reg;
          full_n = 1'b0;
          state_n = START;
        end else if (accept) begin
          shift_n = tx_data;
          state_n = START;
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    txd_n = state_n == START  ? 1'b0 :
            state_n == DATA   ? shift_n[bit_n] :
            state_n == PARITY ? (^shift_n) ^ (PARITY_ODD != 0) : 1'b1;
  end
  // state register; reset abandons any frame and forces the line high immediately
  always_ff @(posedge clk_16x or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      shift_reg <= '0;
      hold_reg <= '0;
      hold_full <= 1'b0;
      txd <= 1'b1;
    end else begin
      state <= state_n;
      tick <= tick_n;
      bit_idx <= bit_n;
      shift_reg <= shift_n;
      hold_reg <= hold_n;
      hold_full <= full_n;
      txd <= txd_n;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, parity variants, queuing, loopback and reset
module tb_uart_tx;
  logic clk_16x = 1'b0, rst = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] ready, txd, busy, done;
  int passed = 0, total = 0;
  logic c_txd [3][0:599];
  logic c_busy [3][0:599];
  logic c_done [3][0:599];
  logic c_ready [0:599];
  logic [7:0] rx_data = 8'h00;
  logic rx_err = 1'b0;
  int rx_count = 0;

  always #5 clk_16x = ~clk_16x;

  uart_tx dut (.clk_16x(clk_16x), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[0]), .txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx #(.PARITY_ODD(1)) dut_odd (.clk_16x(clk_16x), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[1]), .txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx #(.PARITY_EN(0)) dut_np (.clk_16x(clk_16x), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[2]), .txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  // reference receiver on the default-parameter line: mid-bit sampling, even parity
  initial begin
    logic [7:0] sh;
    logic e;
    forever begin
      @(negedge clk_16x);
      if (rst && txd[0] === 1'b0) begin
        repeat (8) @(negedge clk_16x);
        e = txd[0] !== 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (16) @(negedge clk_16x);
          sh[k] = txd[0];
        end
        repeat (16) @(negedge clk_16x);
        e = e | (txd[0] !== ^sh);
        repeat (16) @(negedge clk_16x);
        e = e | (txd[0] !== 1'b1);
        rx_data = sh;
        rx_err = e;
        rx_count++;
      end
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int slot, input logic pen, input logic podd);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && pen) return (^b) ^ podd;
    return 1'b1;
  endfunction

  function automatic logic slot_bit(input int d, input int base);
    for (int k = 1; k < 16; k++) if (c_txd[d][base+k] !== c_txd[d][base]) return 1'bx;
    return c_txd[d][base];
  endfunction

  task automatic sample(input int i);
    for (int d = 0; d < 3; d++) begin
      c_txd[d][i] = txd[d];
      c_busy[d][i] = busy[d];
      c_done[d][i] = done[d];
    end
    c_ready[i] = ready[0];
  endtask

  task automatic push_idle(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk_16x);
    tx_valid = 1'b0;
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      sample(i);
      @(negedge clk_16x);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk_16x);
    total++; if (txd[0] !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd[0]); else passed++;
    total++; if (ready[0] !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready[0]); else passed++;
    total++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy[0]); else passed++;
    total++; if (done[0] !== 1'b0) $display("FAIL reset_done: got %b want 0", done[0]); else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk_16x);
    total++; if (txd[0] !== 1'b1 || busy[0] !== 1'b0) $display("FAIL release_idle: got txd=%b busy=%b want 1/0", txd[0], busy[0]); else passed++;
  endtask

  task automatic test_frame;
    int nb, nd;
    push_idle(8'hA5);
    record(190);
    for (int s = 0; s < 11; s++) begin
      total++;
      if (slot_bit(0, s*16) !== exp_bit(8'hA5, s, 1'b1, 1'b0)) $display("FAIL a5_slot%0d: got %b want %b", s, slot_bit(0, s*16), exp_bit(8'hA5, s, 1'b1, 1'b0));
      else passed++;
    end
    nb = 0;
    nd = 0;
    for (int i = 0; i < 190; i++) begin
      nb += int'(c_busy[0][i]);
      nd += int'(c_done[0][i]);
    end
    total++; if (nb != 176 || c_busy[0][0] !== 1'b1) $display("FAIL a5_busy_len: got %0d want 176", nb); else passed++;
    total++; if (nd != 1 || c_done[0][175] !== 1'b1) $display("FAIL a5_done: got count %0d at175=%b want 1/1", nd, c_done[0][175]); else passed++;
  endtask

  task automatic test_parity;
    int nb;
    push_idle(8'h01);
    record(190);
    total++; if (slot_bit(0, 144) !== 1'b1) $display("FAIL even_parity_01: got %b want 1", slot_bit(0, 144)); else passed++;
    total++; if (slot_bit(1, 144) !== 1'b0) $display("FAIL odd_parity_01: got %b want 0", slot_bit(1, 144)); else passed++;
    for (int s = 0; s < 11; s++) begin
      total++;
      if (slot_bit(1, s*16) !== exp_bit(8'h01, s, 1'b1, 1'b1)) $display("FAIL odd_slot%0d: got %b want %b", s, slot_bit(1, s*16), exp_bit(8'h01, s, 1'b1, 1'b1));
      else passed++;
    end
    total++; if (slot_bit(2, 128) !== 1'b0 || slot_bit(2, 144) !== 1'b1) $display("FAIL np_bit7_stop: got %b%b want 01", slot_bit(2, 128), slot_bit(2, 144)); else passed++;
    nb = 0;
    for (int i = 0; i < 190; i++) nb += int'(c_busy[2][i]);
    total++; if (nb != 160) $display("FAIL np_busy_len: got %0d want 160", nb); else passed++;
    total++; if (c_done[2][159] !== 1'b1 || c_busy[2][160] !== 1'b0) $display("FAIL np_done_end: got done159=%b busy160=%b want 1/0", c_done[2][159], c_busy[2][160]); else passed++;
  endtask

  task automatic test_back_to_back;
    int nb, nd, nr, got33;
    logic [7:0] fb [3];
    bit drop;
    fb = '{8'h55, 8'h0F, 8'h33};
    got33 = -1;
    drop = 0;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    for (int i = 0; i < 560; i++) begin
      @(negedge clk_16x);
      sample(i);
      if (drop) begin
        tx_valid = 1'b0;
        drop = 0;
      end
      if (i == 0) tx_valid = 1'b0;
      if (i == 19) begin
        tx_data = 8'h0F;
        tx_valid = 1'b1;
      end
      if (i == 20) tx_data = 8'h33;
      if (i >= 20 && tx_valid && ready[0] && got33 < 0) begin
        got33 = i;
        drop = 1;
      end
    end
    tx_valid = 1'b0;
    total++; if (c_ready[20] !== 1'b0) $display("FAIL ready_after_0f: got %b want 0", c_ready[20]); else passed++;
    nr = 0;
    for (int i = 20; i < 176; i++) nr += int'(c_ready[i]);
    total++; if (nr != 0) $display("FAIL ready_held_low: got %0d high cycles want 0", nr); else passed++;
    total++; if (got33 != 176) $display("FAIL accept_33_cycle: got %0d want 176", got33); else passed++;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 11; s++) begin
        total++;
        if (slot_bit(0, f*176 + s*16) !== exp_bit(fb[f], s, 1'b1, 1'b0)) $display("FAIL b2b_f%0d_slot%0d: got %b want %b", f, s, slot_bit(0, f*176 + s*16), exp_bit(fb[f], s, 1'b1, 1'b0));
        else passed++;
      end
    nb = 0;
    nd = 0;
    for (int i = 0; i < 528; i++) nb += int'(c_busy[0][i]);
    for (int i = 0; i < 560; i++) nd += int'(c_done[0][i]);
    total++; if (nb != 528 || c_busy[0][528] !== 1'b0) $display("FAIL b2b_busy: got %0d end=%b want 528/0", nb, c_busy[0][528]); else passed++;
    total++; if (nd != 3 || c_done[0][175] !== 1'b1 || c_done[0][351] !== 1'b1 || c_done[0][527] !== 1'b1) $display("FAIL b2b_done: got count %0d want 3 at 175/351/527", nd); else passed++;
  endtask

  task automatic test_loopback;
    logic [7:0] v [4];
    int c0, w;
    v = '{8'h00, 8'hFF, 8'h3C, 8'hC3};
    for (int k = 0; k < 4; k++) begin
      c0 = rx_count;
      w = 0;
      push_idle(v[k]);
      while (rx_count == c0 && w < 400) begin
        @(negedge clk_16x);
        w++;
      end
      total++; if (rx_count == c0) $display("FAIL loop_ready_%0h: got no frame want data_ready", v[k]); else passed++;
      total++; if (rx_data !== v[k] || rx_err !== 1'b0) $display("FAIL loop_data_%0h: got %h err=%b want %h err=0", v[k], rx_data, rx_err, v[k]); else passed++;
    end
    w = 0;
    while (busy[0] && w < 400) begin
      @(negedge clk_16x);
      w++;
    end
    total++; if (busy[0] !== 1'b0) $display("FAIL loop_idle: got busy=%b want 0", busy[0]); else passed++;
  endtask

  task automatic test_reset_mid;
    int nb, nt;
    push_idle(8'h0F);
    repeat (10) @(negedge clk_16x);
    tx_data = 8'h22;
    tx_valid = 1'b1;
    @(negedge clk_16x);
    tx_valid = 1'b0;
    total++; if (ready[0] !== 1'b0) $display("FAIL mid_hold_full: got ready=%b want 0", ready[0]); else passed++;
    repeat (74) @(negedge clk_16x);
    total++; if (txd[0] !== 1'b0) $display("FAIL mid_bit4: got %b want 0", txd[0]); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (txd[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) $display("FAIL async_reset: got txd=%b ready=%b busy=%b done=%b want 1/1/0/0", txd[0], ready[0], busy[0], done[0]); else passed++;
    repeat (2) @(negedge clk_16x);
    rst = 1'b1;
    record(200);
    nb = 0;
    nt = 0;
    for (int i = 0; i < 200; i++) begin
      nb += int'(c_busy[0][i]);
      nt += int'(c_txd[0][i]);
    end
    total++; if (nb != 0 || nt != 200) $display("FAIL no_residual: got busy=%0d txd_high=%0d want 0/200", nb, nt); else passed++;
    push_idle(8'h81);
    record(180);
    for (int s = 0; s < 11; s++) begin
      total++;
      if (slot_bit(0, s*16) !== exp_bit(8'h81, s, 1'b1, 1'b0)) $display("FAIL post_reset_81_slot%0d: got %b want %b", s, slot_bit(0, s*16), exp_bit(8'h81, s, 1'b1, 1'b0));
      else passed++;
    end
  endtask

  task automatic test_stop_edge;
    int nb, nd;
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    for (int i = 0; i < 370; i++) begin
      @(negedge clk_16x);
      sample(i);
      if (i == 0) tx_valid = 1'b0;
      if (i == 175) begin
        tx_data = 8'h7E;
        tx_valid = 1'b1;
      end
      if (i == 176) tx_valid = 1'b0;
    end
    total++; if (c_ready[175] !== 1'b1 || c_done[0][175] !== 1'b1) $display("FAIL edge_stop_tick: got ready=%b done=%b want 1/1", c_ready[175], c_done[0][175]); else passed++;
    for (int s = 0; s < 11; s++) begin
      total++;
      if (slot_bit(0, 176 + s*16) !== exp_bit(8'h7E, s, 1'b1, 1'b0)) $display("FAIL edge_7e_slot%0d: got %b want %b", s, slot_bit(0, 176 + s*16), exp_bit(8'h7E, s, 1'b1, 1'b0));
      else passed++;
    end
    nb = 0;
    nd = 0;
    for (int i = 0; i < 352; i++) nb += int'(c_busy[0][i]);
    for (int i = 0; i < 370; i++) nd += int'(c_done[0][i]);
    total++; if (nb != 352 || c_busy[0][352] !== 1'b0) $display("FAIL edge_busy: got %0d end=%b want 352/0", nb, c_busy[0][352]); else passed++;
    total++; if (nd != 2 || c_done[0][351] !== 1'b1) $display("FAIL edge_done: got count %0d want 2 at 175/351", nd); else passed++;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_parity;
    test_back_to_back;
    test_loopback;
    test_reset_mid;
    test_stop_edge;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter clocked by the 16x baud sampling clock.
- It serialises bytes into frames: start, 8 data bits LSB first, optional parity, one stop bit.
- Frame format and bit timing match the design's UART receiver: 16 clk_16x cycles per bit.
- Has a one-entry holding register so a producer (e.g. car-status reporter) can queue the next byte while a frame is on the line; frames then run back-to-back without a gap.

Parameters:
- PARITY_EN, 1, 1 = parity bit inserted after data bit 7; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd (inverted XOR).
- OVERSAMPLE, 16, clk_16x cycles per bit; must be >= 2.

Ports:
- clk_16x  input  1  16x baud clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  holding register empty, so a byte can be accepted this cycle.
- txd  output  1  serial line; idles high; registered output.
- tx_busy  output  1  high while a frame (start..stop) is being driven.
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (rst = 0, asynchronous, effective immediately):
  - txd = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - FSM = IDLE, tick and bit counters = 0, holding register emptied.
  - A frame in progress is abandoned; txd returns high at once.
  - Release is synchronous to the next edge. No glitch on txd.
- FSM states:
  - IDLE: txd = 1.
  - START: txd = 0 for OVERSAMPLE cycles.
  - DATA: 8 bits, shift_reg[0] first, OVERSAMPLE cycles each.
  - PARITY: present only if PARITY_EN; OVERSAMPLE cycles.
  - STOP: txd = 1 for OVERSAMPLE cycles.
- Counters:
  - Tick counter counts 0..OVERSAMPLE-1; wraps to 0 at each bit boundary.
  - Bit index counts 0..7 within DATA.
- Handshake: a transfer occurs on an edge where tx_valid && tx_ready. tx_data is ignored otherwise.
- Transfer while IDLE:
  - Byte goes directly to shift_reg, FSM enters START, txd = 0 after that same edge.
  - Latency: 1 cycle from accept edge to start-bit edge.
  - tx_ready stays 1, because the holding register is still empty.
- Transfer while busy: byte goes to the holding register; tx_ready = 0 until it is consumed.
- Parity is computed from the byte latched into shift_reg, not from live tx_data.
- Frame timing:
  - Frame length = OVERSAMPLE*(10+PARITY_EN) cycles: 176 at default, 160 without parity.
  - tx_busy is high for exactly that many cycles per frame.
- Last STOP tick (tick = OVERSAMPLE-1):
  - tx_done = 1 for this cycle only.
  - If the holding register is full: move it to shift_reg, empty it, enter START; tx_busy stays 1. The next start bit follows the stop bit with zero idle cycles.
  - Else if tx_valid && tx_ready on this same edge: the byte goes directly to shift_reg and START, no gap.
  - Else: go to IDLE, tx_busy = 0.
- Holding register full and tx_valid asserted: the producer must hold tx_valid/tx_data; nothing is dropped or overwritten.
- tx_valid deasserted mid-frame has no effect on the current frame.
- The frame continues regardless of input changes; there is no abort except reset.

Test Plan:
1. Reset, then push 0xA5 with default parameters.
   - txd: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each bit exactly 16 cycles.
   - tx_busy high for 176 cycles; tx_done pulses once, on cycle 176.
2. Push 0x01 with PARITY_ODD = 0, then with PARITY_ODD = 1.
   - Parity bit = 1 with PARITY_ODD = 0; parity bit = 0 with PARITY_ODD = 1.
   - PARITY_EN = 0: frame is 160 cycles and has no parity slot.
3. Push 0x55, then push 0x0F 20 cycles later. Hold tx_valid with 0x33 throughout.
   - tx_ready = 0 after 0x0F is accepted.
   - 0x0F's start bit begins the cycle after 0x55's stop ends.
   - 0x33 is accepted only when 0x0F moves to shift_reg.
   - Three consecutive frames, no idle gap, no byte lost.
4. Loopback: connect txd to the receiver's rxd, using the same clk_16x.
   - Send 0x00, 0xFF, 0x3C, 0xC3.
   - Receiver data_rec matches each byte; data_ready asserts and data_error = 0 for every frame.
5. Assert rst low mid-frame, at data bit 4 with a byte in the holding register.
   - txd = 1 and tx_ready = 1 asynchronously, tx_busy = 0.
   - After release, no residual frame is sent.
   - A new push of 0x81 produces a clean frame.
6. Drive tx_valid on the exact final STOP tick with the holding register empty, byte 0x7E.
   - tx_done pulses, and 0x7E's start bit follows immediately.
   - tx_busy never drops.
